// File: rtl/cnn_upsample_2x_multi_channel.sv
// Nearest-neighbour 2x upsampler for channel-sequential raster pixel streams.
// Optional macro CNN_UPSAMPLE_LAST_EN adds the registered end-of-channel flag last_out.
module cnn_upsample_2x_multi_channel #(
    parameter int DATA_WIDTH     = 32,
    parameter int IMAGE_WIDTH    = 64,
    parameter int IMAGE_HEIGHT   = 64,
    parameter int CHANNEL_NUM_IN = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic                  ready_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out
`ifdef CNN_UPSAMPLE_LAST_EN
    ,
    output logic                  last_out
`endif
);

    localparam int CW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int HW = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMAGE_HEIGHT - 1);
    localparam logic [HW-1:0] CHAN_LAST = HW'(CHANNEL_NUM_IN - 1);

    typedef enum logic {
        ROW_A,
        ROW_B
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  phase;
    logic                  phase_nxt;
    logic [CW-1:0]         col;
    logic [CW-1:0]         col_nxt;
    logic [RW-1:0]         row;
    logic [RW-1:0]         row_nxt;
    logic [HW-1:0]         chan;
    logic [HW-1:0]         chan_nxt;
    logic [DATA_WIDTH-1:0] pxl_nxt;
    logic                  valid_nxt;
    logic                  transfer;
    logic                  col_end;
    logic                  row_end;
    logic                  last_nxt;

    logic [DATA_WIDTH-1:0] linebuf [IMAGE_WIDTH];

    assign ready_in = (state == ROW_A) && !phase;
    assign transfer = valid_in && ready_in;
    assign col_end  = (col == COL_LAST);
    assign row_end  = (row == ROW_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ROW_A;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        col_nxt   = col;
        row_nxt   = row;
        chan_nxt  = chan;
        pxl_nxt   = pxl_out;
        valid_nxt = 1'b0;
        last_nxt  = 1'b0;
        unique case (state)
            ROW_A: begin
                if (!phase) begin
                    if (transfer) begin
                        pxl_nxt   = pxl_in;
                        valid_nxt = 1'b1;
                        phase_nxt = 1'b1;
                    end
                end else begin
                    valid_nxt = 1'b1;
                    phase_nxt = 1'b0;
                    if (col_end) begin
                        col_nxt   = '0;
                        state_nxt = ROW_B;
                    end else begin
                        col_nxt = col + 1'b1;
                    end
                end
            end
            ROW_B: begin
                // Replay the buffered row; each word is shown on two consecutive cycles.
                valid_nxt = 1'b1;
                pxl_nxt   = linebuf[col];
                phase_nxt = !phase;
                last_nxt  = phase && col_end && row_end;
                if (phase) begin
                    if (col_end) begin
                        col_nxt   = '0;
                        state_nxt = ROW_A;
                        if (row_end) begin
                            row_nxt  = '0;
                            chan_nxt = (chan == CHAN_LAST) ? '0 : chan + 1'b1;
                        end else begin
                            row_nxt = row + 1'b1;
                        end
                    end else begin
                        col_nxt = col + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase     <= 1'b0;
            col       <= '0;
            row       <= '0;
            chan      <= '0;
            pxl_out   <= '0;
            valid_out <= 1'b0;
        end else begin
            phase     <= phase_nxt;
            col       <= col_nxt;
            row       <= row_nxt;
            chan      <= chan_nxt;
            pxl_out   <= pxl_nxt;
            valid_out <= valid_nxt;
        end
    end

`ifdef CNN_UPSAMPLE_LAST_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_out <= 1'b0;
        end else begin
            last_out <= last_nxt;
        end
    end
`else
    logic unused_last;
    assign unused_last = last_nxt;
`endif

    // Line buffer holds no reset state; it is always written before being replayed.
    always_ff @(posedge clk) begin
        if (transfer) begin
            linebuf[col] <= pxl_in;
        end
    end

endmodule

// File: tb/tb_cnn_upsample_2x_multi_channel.sv
// Directed and randomised bench for the 2x upsampler against a stream model.
// Honours CNN_UPSAMPLE_LAST_EN when defined at compile time.
module tb_cnn_upsample_2x_multi_channel;

    localparam int DW = 32;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int C  = 2;
    localparam int CH_OUTS = 4 * W * H;

    logic          clk;
    logic          reset;
    logic          valid_in;
    logic [DW-1:0] pxl_in;
    logic          ready_in;
    logic [DW-1:0] pxl_out;
    logic          valid_out;
`ifdef CNN_UPSAMPLE_LAST_EN
    logic          last_out;
`endif

    cnn_upsample_2x_multi_channel #(
        .DATA_WIDTH    (DW),
        .IMAGE_WIDTH   (W),
        .IMAGE_HEIGHT  (H),
        .CHANNEL_NUM_IN(C)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_in (valid_in),
        .pxl_in   (pxl_in),
        .ready_in (ready_in),
        .pxl_out  (pxl_out),
        .valid_out(valid_out)
`ifdef CNN_UPSAMPLE_LAST_EN
        ,
        .last_out (last_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk  = 0;
    int nfail = 0;

    logic [DW-1:0] expq [$];
    logic [DW-1:0] row_q [$];
    logic [DW-1:0] log_q [$];
    int out_idx  = 0;
    int idle_cnt = 0;

    task automatic chk(input string name, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Model: every pixel appears twice, then the whole row replays doubled.
    task automatic model_push(input logic [DW-1:0] p);
        expq.push_back(p);
        expq.push_back(p);
        row_q.push_back(p);
        if (row_q.size() == W) begin
            foreach (row_q[i]) begin
                expq.push_back(row_q[i]);
                expq.push_back(row_q[i]);
            end
            row_q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (valid_out) begin
                if (expq.size() == 0) begin
                    chk("unexpected_output", pxl_out, 'x);
                end else begin
                    chk("stream_pixel", pxl_out, expq.pop_front());
                end
                log_q.push_back(pxl_out);
`ifdef CNN_UPSAMPLE_LAST_EN
                chk("last_out", {31'd0, last_out},
                    {31'd0, (out_idx % CH_OUTS) == CH_OUTS - 1});
`endif
                out_idx++;
            end else begin
                idle_cnt++;
`ifdef CNN_UPSAMPLE_LAST_EN
                chk("last_out_idle", {31'd0, last_out}, 32'd0);
`endif
            end
        end
    end

    task automatic do_reset();
        valid_in = 1'b0;
        pxl_in   = '0;
        reset    = 1'b1;
        #1;
        chk("reset_valid_out", {31'd0, valid_out}, 32'd0);
        chk("reset_pxl_out", pxl_out, 32'd0);
        chk("reset_ready_in", {31'd0, ready_in}, 32'd1);
        expq.delete();
        row_q.delete();
        log_q.delete();
        out_idx = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] p);
        logic acc;
        int   n;
        valid_in = 1'b1;
        pxl_in   = p;
        model_push(p);
        n = 0;
        forever begin
            acc = ready_in;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 50) begin
                chk("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() > 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", expq.size(), 32'd0);
    endtask

    logic [DW-1:0] lit2 [16] = '{1, 1, 2, 2, 3, 3, 4, 4, 1, 1, 2, 2, 3, 3, 4, 4};
    logic [DW-1:0] lit5 [16] = '{9, 9, 10, 10, 11, 11, 12, 12,
                                 9, 9, 10, 10, 11, 11, 12, 12};

    initial begin
        int idle0;
        valid_in = 1'b0;
        pxl_in   = '0;
        reset    = 1'b1;
        @(posedge clk);

        // Reset state and quiet idle
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("idle_valid_out", {31'd0, valid_out}, 32'd0);
        end

        // One row, valid held during replay
        send(1);
        idle0 = idle_cnt;
        for (int p = 2; p <= 4; p++) send(DW'(p));
        valid_in = 1'b1;
        pxl_in   = 32'd5;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("replay_ready_low", {31'd0, ready_in}, 32'd0);
            @(posedge clk);
            #1;
        end
        chk("ready_after_replay", {31'd0, ready_in}, 32'd1);
        valid_in = 1'b0;
        drain();
        chk("row_no_gap", idle_cnt - idle0, 32'd0);
        chk("row_count", log_q.size(), 32'd16);
        for (int i = 0; i < 16; i++) chk("row_literal", log_q[i], lit2[i]);

        // Full frame, continuous input
        do_reset();
        send(1);
        idle0 = idle_cnt;
        for (int p = 2; p <= 16; p++) send(DW'(p));
        drain();
        chk("frame_no_gap", idle_cnt - idle0, 32'd0);
        chk("frame_count", log_q.size(), 32'd64);
        chk("frame_o0", log_q[0], 32'd1);
        chk("frame_o8", log_q[8], 32'd1);
        chk("frame_o16", log_q[16], 32'd5);
        chk("frame_o31", log_q[31], 32'd8);
        chk("frame_o32", log_q[32], 32'd9);
        chk("frame_o63", log_q[63], 32'd16);

        // Input gap of three ready cycles
        do_reset();
        send(1);
        idle0 = idle_cnt;
        send(2);
        valid_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        send(3);
        send(4);
        drain();
        chk("gap_idle", idle_cnt - idle0, 32'd3);
        for (int i = 0; i < 16; i++) chk("gap_literal", log_q[i], lit2[i]);

        // Reset during replay
        do_reset();
        for (int p = 1; p <= 4; p++) send(DW'(p));
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midreset_valid", {31'd0, valid_out}, 32'd0);
        chk("midreset_pxl", pxl_out, 32'd0);
        reset = 1'b0;
        do_reset();
        for (int p = 9; p <= 12; p++) send(DW'(p));
        drain();
        chk("midreset_count", log_q.size(), 32'd16);
        for (int i = 0; i < 16; i++) chk("midreset_literal", log_q[i], lit5[i]);

        // Random valid over two frames
        do_reset();
        for (int i = 0; i < 2 * W * H * C; i++) begin
            while ($urandom_range(1) == 0) begin
                @(posedge clk);
                #1;
            end
            send($urandom);
        end
        drain();
        chk("random_count", log_q.size(), 32'(2 * W * H * C * 4));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
